// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family: direction and end-of-range
// mode encodings, plus a ceil-log2 helper used to size the prescaler.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  function automatic int clog2(input longint unsigned n);
    longint unsigned v;
    int r;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the count enable: tick fires on every PRESCALE-th cycle that has en high.
// clr (parallel load) and reset both return the phase to zero.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("counter_prescaler: PRESCALE must be at least 2");
  end

  logic [PW-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous modulo-MODULUS up/down counter with parallel load, wrap or saturate
// mode, a combinational terminal count for cascading and a registered wrap pulse.
// Define UPDOWN_COUNTER_PRESCALE_EN to divide the count enable by PRESCALE.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MODULUS  = 16,
  parameter int     SATURATE = 0
`ifdef UPDOWN_COUNTER_PRESCALE_EN
  ,
  parameter int     PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be in 2..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS must be in 2..2**WIDTH");
  end
  if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_mode
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  // Top of range at full width; for MODULUS == 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic tick;
  logic at_max;
  logic at_min;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );
`else
  assign tick = en;
`endif

  assign at_max = (q == MAX);
  assign at_min = (q == '0);
  assign tc     = tick & ((up_dn == CNT_DOWN) ? at_min : at_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= (load_val > MAX) ? MAX : load_val;
      wrap <= 1'b0;
    end else if (tick) begin
      wrap <= 1'b0;
      if (up_dn == CNT_UP) begin
        if (!at_max) begin
          q <= q + WIDTH'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q    <= '0;
          wrap <= 1'b1;
        end
      end else begin
        if (!at_min) begin
          q <= q - WIDTH'(1);
        end else if (SATURATE == CNT_WRAP) begin
          q    <= MAX;
          wrap <= 1'b1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
